// File: rtl/caliptra_generic_wire_fifo_if.sv
// Host-side drain port of the generic wire capture FIFO: head entry plus valid/ready.
// The FIFO drives valid/data/channel; the host drives ready.
interface caliptra_generic_wire_fifo_if #(
  parameter int DATA_W = 32,
  parameter int CH_W   = 1
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;

  modport master (output out_valid, output out_data, output out_ch, input out_ready);
  modport slave  (input out_valid, input out_data, input out_ch, output out_ready);
endinterface

// File: rtl/caliptra_generic_wire_fifo.sv
// Captures per-channel generic wire strobes into holding registers and merges them
// round-robin into one shared FIFO drained by the host; unholdable events are counted.
module caliptra_generic_wire_fifo #(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int DROP_W = 8
) (
  input  logic                       clk,
  input  logic                       cptra_rst_b,
  input  logic [NUM_CH-1:0]          load_en,
  input  logic [NUM_CH*DATA_W-1:0]   load_data,
  input  logic                       flush,
  input  logic                       drop_clr,
  caliptra_generic_wire_fifo_if.master out_if,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic [NUM_CH*DROP_W-1:0]   drop_cnt
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int AW   = $clog2(DEPTH);

  logic [NUM_CH-1:0] hold_v_q, hold_v_d;
  logic [NUM_CH-1:0] hold_we;
  logic [DATA_W-1:0] hold_data_q [NUM_CH];
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [CH_W-1:0]   mem_ch_q [DEPTH];
  logic [DROP_W-1:0] drop_cnt_q [NUM_CH];
  logic [DROP_W-1:0] drop_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] ch_drop;

  logic            empty, full, pop, push;
  logic            gnt_any;
  logic [CH_W-1:0] gnt_idx;
  logic [CH_W:0]   rr_sum;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !flush && !empty && out_if.out_ready;
  assign fifo_count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_sum = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (rr_sum >= (CH_W+1)'(NUM_CH)) begin
        rr_sum = rr_sum - (CH_W+1)'(NUM_CH);
      end
      if (!gnt_any && hold_v_q[rr_sum[CH_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = rr_sum[CH_W-1:0];
      end
    end
  end

  // A full FIFO still takes a push when the host pops in the same cycle.
  assign push = !flush && gnt_any && (!full || pop);

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    hold_v_d = hold_v_q;
    hold_we  = '0;
    ch_drop  = '0;
    if (flush) begin
      rr_ptr_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      hold_v_d = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      if (push) begin
        wr_ptr_d          = wr_ptr_q + (AW+1)'(1);
        hold_v_d[gnt_idx] = 1'b0;
        rr_ptr_d          = (gnt_idx == CH_W'(NUM_CH-1)) ? '0 : gnt_idx + CH_W'(1);
      end
      for (int c = 0; c < NUM_CH; c++) begin
        if (load_en[c]) begin
          if (!hold_v_d[c]) begin
            hold_v_d[c] = 1'b1;
            hold_we[c]  = 1'b1;
          end else begin
            ch_drop[c] = 1'b1;
          end
        end
      end
    end
  end

  // Clear beats a coincident drop; counters stick at all-ones.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      drop_cnt_d[c] = drop_cnt_q[c];
      if (drop_clr) begin
        drop_cnt_d[c] = '0;
      end else if (ch_drop[c] && (drop_cnt_q[c] != {DROP_W{1'b1}})) begin
        drop_cnt_d[c] = drop_cnt_q[c] + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge cptra_rst_b) begin
    if (!cptra_rst_b) begin
      hold_v_q <= '0;
      rr_ptr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        drop_cnt_q[c] <= '0;
      end
    end else begin
      hold_v_q <= hold_v_d;
      rr_ptr_q <= rr_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      for (int c = 0; c < NUM_CH; c++) begin
        drop_cnt_q[c] <= drop_cnt_d[c];
      end
    end
  end

  // Payload storage is qualified by the valid/pointer state, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q[AW-1:0]] <= hold_data_q[gnt_idx];
      mem_ch_q[wr_ptr_q[AW-1:0]]   <= gnt_idx;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      if (hold_we[c]) begin
        hold_data_q[c] <= load_data[c*DATA_W +: DATA_W];
      end
    end
  end

  assign out_if.out_valid = !empty;
  assign out_if.out_data  = empty ? '0 : mem_data_q[rd_ptr_q[AW-1:0]];
  assign out_if.out_ch    = empty ? '0 : mem_ch_q[rd_ptr_q[AW-1:0]];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_drop_out
    assign drop_cnt[g*DROP_W +: DROP_W] = drop_cnt_q[g];
  end

endmodule

// File: tb/tb_caliptra_generic_wire_fifo.sv
// Directed bench for caliptra_generic_wire_fifo with a queue-based reference model
// checked every cycle, plus literal expectations for each scenario.
module tb_caliptra_generic_wire_fifo;
  localparam int NCH   = 2;
  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int DRW   = 2;
  localparam int MAXD  = 3;

  logic            clk;
  logic            rst_n;
  logic [NCH-1:0]  load_en;
  logic [NCH*DW-1:0] load_data;
  logic            flush;
  logic            drop_clr;
  logic [4:0]      fifo_count;
  logic [NCH*DRW-1:0] drop_cnt;

  caliptra_generic_wire_fifo_if #(.DATA_W(DW), .CH_W(1)) ofi ();

  caliptra_generic_wire_fifo #(.NUM_CH(NCH), .DATA_W(DW), .DEPTH(DEPTH), .DROP_W(DRW)) dut (
    .clk         (clk),
    .cptra_rst_b (rst_n),
    .load_en     (load_en),
    .load_data   (load_data),
    .flush       (flush),
    .drop_clr    (drop_clr),
    .out_if      (ofi),
    .fifo_count  (fifo_count),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: FIFO as a queue, holds as plain arrays.
  int          q_ch[$];
  logic [31:0] q_data[$];
  bit          m_hv[NCH];
  logic [31:0] m_hd[NCH];
  int          m_rr;
  int          m_drop[NCH];
  bit          m_dropev[NCH];
  bit          m_pop;
  int          m_g;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ch.delete();
      q_data.delete();
      m_rr = 0;
      for (int c = 0; c < NCH; c++) begin
        m_hv[c] = 0;
        m_drop[c] = 0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) m_dropev[c] = 0;
      if (flush) begin
        q_ch.delete();
        q_data.delete();
        m_rr = 0;
        for (int c = 0; c < NCH; c++) m_hv[c] = 0;
      end else begin
        m_pop = (q_ch.size() > 0) && (ofi.out_ready === 1'b1);
        m_g = -1;
        if (q_ch.size() < DEPTH || m_pop) begin
          for (int i = 0; i < NCH; i++) begin
            if (m_g < 0 && m_hv[(m_rr + i) % NCH]) m_g = (m_rr + i) % NCH;
          end
        end
        if (m_pop) begin
          void'(q_ch.pop_front());
          void'(q_data.pop_front());
        end
        if (m_g >= 0) begin
          q_ch.push_back(m_g);
          q_data.push_back(m_hd[m_g]);
          m_hv[m_g] = 0;
          m_rr = (m_g + 1) % NCH;
        end
        for (int c = 0; c < NCH; c++) begin
          if (load_en[c]) begin
            if (!m_hv[c]) begin
              m_hv[c] = 1;
              m_hd[c] = load_data[c*DW +: DW];
            end else begin
              m_dropev[c] = 1;
            end
          end
        end
      end
      for (int c = 0; c < NCH; c++) begin
        if (drop_clr) m_drop[c] = 0;
        else if (m_dropev[c] && m_drop[c] < MAXD) m_drop[c]++;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("m_valid", 64'(ofi.out_valid), 64'(q_ch.size() != 0));
      chk("m_count", 64'(fifo_count), 64'(q_ch.size()));
      if (q_ch.size() != 0) begin
        chk("m_data", 64'(ofi.out_data), 64'(q_data[0]));
        chk("m_ch", 64'(ofi.out_ch), 64'(q_ch[0]));
      end
      chk("m_drop0", 64'(drop_cnt[1:0]), 64'(m_drop[0]));
      chk("m_drop1", 64'(drop_cnt[3:2]), 64'(m_drop[1]));
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_ld(input logic [1:0] en, input logic [31:0] d0, input logic [31:0] d1);
    load_en   = en;
    load_data = {d1, d0};
  endtask

  initial begin
    rst_n = 1'b0;
    load_en = '0;
    load_data = '0;
    flush = 1'b0;
    drop_clr = 1'b0;
    ofi.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(ofi.out_valid), 64'd0);
    chk("rst_data", 64'(ofi.out_data), 64'd0);
    chk("rst_ch", 64'(ofi.out_ch), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_drop", 64'(drop_cnt), 64'd0);
    rst_n = 1'b1;

    // single event on ch0
    set_ld(2'b01, 32'hA5A5_0001, 32'h0);
    tick();
    set_ld(2'b00, 32'h0, 32'h0);
    chk("single_lat1_valid", 64'(ofi.out_valid), 64'd0);
    tick();
    chk("single_valid", 64'(ofi.out_valid), 64'd1);
    chk("single_data", 64'(ofi.out_data), 64'hA5A5_0001);
    chk("single_ch", 64'(ofi.out_ch), 64'd0);
    ofi.out_ready = 1'b1;
    tick();
    ofi.out_ready = 1'b0;
    chk("single_pop_count", 64'(fifo_count), 64'd0);
    chk("single_pop_valid", 64'(ofi.out_valid), 64'd0);

    // simultaneous loads on both channels, rr_ptr back to 0 via flush
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int r = 0; r < 2; r++) begin
      set_ld(2'b11, 32'h11, 32'h22);
      tick();
      set_ld(2'b00, 32'h0, 32'h0);
      tick();
      chk("simul_first_count", 64'(fifo_count), 64'd1);
      chk("simul_first_ch", 64'(ofi.out_ch), 64'd0);
      chk("simul_first_data", 64'(ofi.out_data), 64'h11);
      tick();
      chk("simul_second_count", 64'(fifo_count), 64'd2);
      ofi.out_ready = 1'b1;
      tick();
      chk("simul_head_ch", 64'(ofi.out_ch), 64'd1);
      chk("simul_head_data", 64'(ofi.out_data), 64'h22);
      tick();
      ofi.out_ready = 1'b0;
      chk("simul_drained", 64'(ofi.out_valid), 64'd0);
    end

    // fill the FIFO from ch1 and overflow the holding register
    for (int k = 1; k <= DEPTH + 3; k++) begin
      set_ld(2'b10, 32'h0, 32'h1000 + 32'(k));
      tick();
    end
    set_ld(2'b00, 32'h0, 32'h0);
    chk("full_count", 64'(fifo_count), 64'd16);
    chk("full_drop1", 64'(drop_cnt[3:2]), 64'd2);
    chk("full_head", 64'(ofi.out_data), 64'h1001);
    ofi.out_ready = 1'b1;
    tick();
    ofi.out_ready = 1'b0;
    chk("full_poppush_count", 64'(fifo_count), 64'd16);
    chk("full_poppush_head", 64'(ofi.out_data), 64'h1002);

    // saturate ch0 drop counter while FIFO stays full
    for (int k = 0; k < 6; k++) begin
      set_ld(2'b01, 32'h2000 + 32'(k), 32'h0);
      tick();
    end
    set_ld(2'b00, 32'h0, 32'h0);
    chk("sat_drop0", 64'(drop_cnt[1:0]), 64'd3);
    drop_clr = 1'b1;
    set_ld(2'b01, 32'h2100, 32'h0);
    tick();
    drop_clr = 1'b0;
    set_ld(2'b00, 32'h0, 32'h0);
    chk("clr_drop_all", 64'(drop_cnt), 64'd0);

    // flush with 5 queued and both holds occupied
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_ld(2'b10, 32'h0, 32'h3000 + 32'(k));
      tick();
    end
    set_ld(2'b11, 32'h4000, 32'h3005);
    tick();
    chk("pre_flush_count", 64'(fifo_count), 64'd5);
    flush = 1'b1;
    ofi.out_ready = 1'b1;
    set_ld(2'b11, 32'h4001, 32'h3006);
    tick();
    flush = 1'b0;
    ofi.out_ready = 1'b0;
    set_ld(2'b00, 32'h0, 32'h0);
    chk("flush_count", 64'(fifo_count), 64'd0);
    chk("flush_valid", 64'(ofi.out_valid), 64'd0);
    chk("flush_drop", 64'(drop_cnt), 64'd0);
    tick();
    chk("flush_holds_clear", 64'(ofi.out_valid), 64'd0);

    // async reset with 3 entries queued
    for (int k = 0; k < 3; k++) begin
      set_ld(2'b01, 32'h5000 + 32'(k), 32'h0);
      tick();
    end
    set_ld(2'b00, 32'h0, 32'h0);
    tick();
    chk("pre_rst_count", 64'(fifo_count), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ofi.out_valid), 64'd0);
    chk("arst_count", 64'(fifo_count), 64'd0);
    chk("arst_data", 64'(ofi.out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", 64'(ofi.out_valid), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/caliptra_generic_wire_fifo.md
# caliptra_generic_wire_fifo

Parametrised capture buffer for the generic output wire strobes of the Caliptra core in the verilated top. Each of NUM_CH channels presents a one-cycle load strobe with data. A per-channel holding register latches each event, and a round-robin arbiter moves held events into one shared FIFO. The C++ host drains the FIFO through a valid/ready port, so back-to-back and simultaneous writes on every channel are preserved in order. Events that cannot be held are dropped and counted per channel.

## Interface
- NUM_CH, default 2: number of generic wire channels (1..8).
- DATA_W, default 32: data width per event.
- DEPTH, default 16: shared FIFO depth in entries; must be a power of 2 and ≥2.
- DROP_W, default 8: width of each per-channel saturating drop counter.
- clk  in  1  core clock; the only clock.
- cptra_rst_b  in  1  asynchronous active-low reset.
- load_en  in  NUM_CH  per-channel load strobe, one event per asserted cycle.
- load_data  in  NUM_CH×DATA_W  per-channel data, sampled when that channel's load_en is high.
- flush  in  1  synchronous clear of the FIFO, the holding registers and the arbiter pointer.
- drop_clr  in  1  synchronous clear of all drop counters.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  host accepts the head entry.
- out_data  out  DATA_W  head entry data.
- out_ch  out  $clog2(NUM_CH) (min 1)  channel index of the head entry.
- fifo_count  out  $clog2(DEPTH)+1  current number of FIFO entries.
- drop_cnt  out  NUM_CH×DROP_W  per-channel count of dropped events.

## Operation
- **Holding register.** One per channel: a valid bit plus DATA_W bits. A load on channel c is accepted when hold_v[c]=0, or when hold_v[c]=1 and channel c is granted in the same cycle. Otherwise the event is dropped and drop_cnt[c] increments, saturating at 2^DROP_W−1.
- **Arbiter.** Each cycle it grants at most one channel with hold_v set, searching round-robin from rr_ptr. It grants only when the FIFO can accept: fifo_count<DEPTH, or fifo_count==DEPTH with a pop in the same cycle.
  - On grant, {c, hold_data[c]} is pushed, hold_v[c] clears (or reloads with the concurrent load), and rr_ptr becomes c+1 mod NUM_CH.
  - rr_ptr is unchanged when nothing is granted.
- **FIFO.** DEPTH-entry circular buffer with write/read pointers one bit wider than the address.
  - Empty when the pointers are equal; full when the MSBs differ and the rest are equal.
  - out_data and out_ch read combinationally from the read-pointer entry.
  - A pop happens when out_valid && out_ready. out_ready while empty has no effect.
  - Simultaneous push and pop leaves fifo_count unchanged, including when the FIFO is full.
- **flush.** Has priority over everything else in its cycle: no push, pop or hold capture occurs, and loads in a flush cycle are discarded without being counted. It clears the pointers, all hold_v bits and rr_ptr. drop_cnt is unaffected.
- **drop_clr.** Zeroes every counter. A drop in the same cycle leaves that counter at 0, i.e. the clear wins.
- **Reset.** Asserting cptra_rst_b low at any time immediately clears all state, including mid-drain.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, fifo_count=0, drop_cnt all 0, hold_v=0, rr_ptr=0.
- Latency, uncontended with the FIFO not full: load_en at edge N → hold at N+1 → pushed at edge N+2 → out_valid high after edge N+2.
- Sustained throughput is one event per cycle in total across all channels.
- With k channels held simultaneously, the last one is pushed k−1 cycles after the first.
- The pop takes effect at the edge where out_valid && out_ready. The next entry, or out_valid=0, is visible after that edge.
- fifo_count and drop_cnt are registered and update at the same edge as the event that changes them.

## Test plan
- **Reset and single event.** Reset, then load_en=01 with data 0xA5A5_0001 for one cycle. Expect out_valid after 2 edges with out_data=0xA5A5_0001 and out_ch=0. Pop it, then expect fifo_count=0 and out_valid=0.
- **Simultaneous channels.** NUM_CH=2, both channels load in the same cycle (ch0=0x11, ch1=0x22) with rr_ptr=0. Expect FIFO order ch0/0x11 then ch1/0x22, pushed on consecutive edges. Repeat and expect the same alternation continues fairly.
- **Full FIFO and drops.** Hold out_ready=0 and stream loads on ch1 every cycle for DEPTH+3 cycles.
  - Expect fifo_count=16 and hold_v[1]=1.
  - Expect drop_cnt[1]=2: the loads arriving once the FIFO is full and hold[1] is occupied.
  - Then pulse out_ready once and expect the held event to enter in the same cycle with fifo_count staying at 16.
- **Saturation and clear.** With DROP_W=2, force 5 drops on ch0 and expect drop_cnt[0]=3. Pulse drop_clr together with a further drop and expect 0.
- **Flush mid-stream.** With 5 entries queued and both holds full, assert flush while out_ready=1 and load_en=11. Next cycle expect fifo_count=0, out_valid=0, no pop consumed, and drop counters unchanged.
- **Async reset mid-drain.** Drop cptra_rst_b low between clock edges while 3 entries are queued. Expect out_valid=0 and fifo_count=0 immediately, with no clock required.
